// File: rtl/bp_me_pkg.sv
// Shared CCE stall-controller types.
// Stall-cause bit positions and widths.
package bp_me_pkg;

   localparam int stall_cause_width_gp = 6;

   typedef enum logic [2:0] {
      e_stall_src    = 3'd0,
      e_stall_sink   = 3'd1,
      e_stall_credit = 3'd2,
      e_stall_wfq    = 3'd3,
      e_stall_fu     = 3'd4,
      e_stall_busy   = 3'd5
   } bp_cce_stall_cause_e;

   typedef logic [stall_cause_width_gp-1:0] bp_cce_stall_cause_t;

endpackage

// File: rtl/bp_cce_inst_stall_ctrl_if.sv
// Decoder <-> stall-controller signal bundle.
// master: decoder / queue side, slave: stall controller.
interface bp_cce_inst_stall_ctrl_if
   import bp_me_pkg::*;
   #(parameter int num_src_q_p       = 4
    ,parameter int num_sink_q_p      = 2
    ,parameter int num_fu_p          = 7
    ,parameter int mem_credits_p     = 8
    ,parameter int watchdog_cycles_p = 1024
    )
   ();

   localparam int credit_width_lp = $clog2(mem_credits_p+1);
   localparam int stall_width_lp  = $clog2(watchdog_cycles_p+1);

   logic                        inst_v_i;
   logic [num_src_q_p-1:0]      src_yumi_req_i;
   logic [num_src_q_p-1:0]      src_v_i;
   logic [num_sink_q_p-1:0]     sink_v_req_i;
   logic [num_sink_q_p-1:0]     sink_ready_and_i;
   logic                        wfq_v_i;
   logic [num_src_q_p-1:0]      wfq_mask_i;
   logic [num_fu_p-1:0]         fu_use_i;
   logic [num_fu_p-1:0]         fu_busy_i;
   logic                        global_busy_i;
   logic                        credit_return_i;
   logic                        watchdog_clr_i;

   logic                        stall_o;
   bp_cce_stall_cause_t         stall_cause_o;
   logic [num_src_q_p-1:0]      src_yumi_o;
   logic [num_sink_q_p-1:0]     sink_v_o;
   logic [credit_width_lp-1:0]  credit_count_o;
   logic                        credits_empty_o;
   logic [stall_width_lp-1:0]   stall_cycles_o;
   logic                        watchdog_o;
   logic                        credit_err_o;

   modport master (
      output inst_v_i, src_yumi_req_i, src_v_i
            ,sink_v_req_i, sink_ready_and_i
            ,wfq_v_i, wfq_mask_i, fu_use_i, fu_busy_i
            ,global_busy_i, credit_return_i, watchdog_clr_i
     ,input  stall_o, stall_cause_o, src_yumi_o, sink_v_o
            ,credit_count_o, credits_empty_o
            ,stall_cycles_o, watchdog_o, credit_err_o
   );

   modport slave (
      input  inst_v_i, src_yumi_req_i, src_v_i
            ,sink_v_req_i, sink_ready_and_i
            ,wfq_v_i, wfq_mask_i, fu_use_i, fu_busy_i
            ,global_busy_i, credit_return_i, watchdog_clr_i
     ,output stall_o, stall_cause_o, src_yumi_o, sink_v_o
            ,credit_count_o, credits_empty_o
            ,stall_cycles_o, watchdog_o, credit_err_o
   );

endinterface

// File: rtl/bp_cce_credit_counter.sv
// Up/down memory-credit counter, resets full.
// A return while full is dropped and latches a sticky overflow flag.
module bp_cce_credit_counter
   #(parameter int max_p   = 8
    ,parameter int width_p = $clog2(max_p+1)
    )
   (input  logic               clk_i
   ,input  logic               reset_i
   ,input  logic               down_i
   ,input  logic               up_i
   ,output logic [width_p-1:0] count_o
   ,output logic               empty_o
   ,output logic               overflow_o
   );

   localparam logic [width_p-1:0] max_lp = width_p'(max_p);
   localparam logic [width_p-1:0] one_lp = width_p'(1);

   logic [width_p-1:0] count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               full, empty;

   assign full  = (count_q == max_lp);
   assign empty = (count_q == '0);

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case ({up_i, down_i})
         2'b10: begin
            if (full) ovf_d = 1'b1;
            else      count_d = count_q + one_lp;
         end
         2'b01: begin
            if (!empty) count_d = count_q - one_lp;
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= max_lp;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o    = count_q;
   assign empty_o    = empty;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/bp_cce_inst_stall_ctrl.sv
// CCE microcode stall controller: hazard causes, gated fires,
// memory credits, consecutive-stall counter and sticky watchdog.
module bp_cce_inst_stall_ctrl
   import bp_me_pkg::*;
   #(parameter int num_src_q_p       = 4
    ,parameter int num_sink_q_p      = 2
    ,parameter int num_fu_p          = 7
    ,parameter int credit_sink_p     = 1
    ,parameter int mem_credits_p     = 8
    ,parameter int watchdog_cycles_p = 1024
    )
   (input  logic clk_i
   ,input  logic reset_i
   ,bp_cce_inst_stall_ctrl_if.slave io
   );

   localparam int credit_width_lp = $clog2(mem_credits_p+1);
   localparam int stall_width_lp  = $clog2(watchdog_cycles_p+1);

   localparam logic [stall_width_lp-1:0] stall_max_lp =
      stall_width_lp'(watchdog_cycles_p);
   localparam logic [stall_width_lp-1:0] stall_trip_lp =
      stall_width_lp'(watchdog_cycles_p-1);
   localparam logic [stall_width_lp-1:0] stall_one_lp =
      stall_width_lp'(1);

   bp_cce_stall_cause_t        cause;
   logic                       stall;
   logic                       fire;
   logic                       credit_send;
   logic [credit_width_lp-1:0] credit_count;
   logic                       credits_empty;
   logic                       credit_err;

   // Causes use only the registered credit count, never this cycle's return.
   always_comb begin
      cause                 = '0;
      cause[e_stall_src]    = |(io.src_yumi_req_i & ~io.src_v_i);
      cause[e_stall_sink]   = |(io.sink_v_req_i & ~io.sink_ready_and_i);
      cause[e_stall_credit] = io.sink_v_req_i[credit_sink_p] & credits_empty;
      cause[e_stall_wfq]    = io.wfq_v_i & ~|(io.wfq_mask_i & io.src_v_i);
      cause[e_stall_fu]     = |(io.fu_use_i & io.fu_busy_i);
      cause[e_stall_busy]   = io.global_busy_i;
      cause = cause & {stall_cause_width_gp{io.inst_v_i}};
   end

   assign stall = |cause;
   assign fire  = io.inst_v_i & ~stall;

   assign io.stall_o       = stall;
   assign io.stall_cause_o = cause;
   assign io.src_yumi_o    = io.src_yumi_req_i & {num_src_q_p{fire}};
   assign io.sink_v_o      = io.sink_v_req_i & {num_sink_q_p{fire}};

   assign credit_send = fire & io.sink_v_req_i[credit_sink_p];

   bp_cce_credit_counter
      #(.max_p(mem_credits_p)
       ,.width_p(credit_width_lp)
       )
      credit_cnt
      (.clk_i(clk_i)
      ,.reset_i(reset_i)
      ,.down_i(credit_send)
      ,.up_i(io.credit_return_i)
      ,.count_o(credit_count)
      ,.empty_o(credits_empty)
      ,.overflow_o(credit_err)
      );

   assign io.credit_count_o  = credit_count;
   assign io.credits_empty_o = credits_empty;
   assign io.credit_err_o    = credit_err;

   logic [stall_width_lp-1:0] stall_cnt_q, stall_cnt_d;
   logic                      wd_q, wd_d;
   logic                      stalled;

   assign stalled = io.inst_v_i & stall;

   // Trip on the watchdog_cycles_p-th consecutive stall; a trip beats a clear.
   always_comb begin
      stall_cnt_d = '0;
      if (stalled) begin
         stall_cnt_d = (stall_cnt_q == stall_max_lp)
                     ? stall_cnt_q
                     : stall_cnt_q + stall_one_lp;
      end
      wd_d = wd_q;
      if (io.watchdog_clr_i) wd_d = 1'b0;
      if (stalled && (stall_cnt_q == stall_trip_lp)) wd_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
         wd_q        <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         wd_q        <= wd_d;
      end
   end

   assign io.stall_cycles_o = stall_cnt_q;
   assign io.watchdog_o     = wd_q;

endmodule

// File: tb/tb_bp_cce_inst_stall_ctrl.sv
// Bench for bp_cce_inst_stall_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the stall rules.
module tb_bp_cce_inst_stall_ctrl;
   import bp_me_pkg::*;

   localparam int NS = 4;
   localparam int NK = 2;
   localparam int NF = 7;
   localparam int CS = 1;
   localparam int MC = 8;
   localparam int WD = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bp_cce_inst_stall_ctrl_if
      #(.num_src_q_p(NS), .num_sink_q_p(NK), .num_fu_p(NF)
       ,.mem_credits_p(MC), .watchdog_cycles_p(WD))
      bus ();

   bp_cce_inst_stall_ctrl
      #(.num_src_q_p(NS), .num_sink_q_p(NK), .num_fu_p(NF)
       ,.credit_sink_p(CS), .mem_credits_p(MC), .watchdog_cycles_p(WD))
      dut
      (.clk_i(clk), .reset_i(rst), .io(bus));

   int checks = 0;
   int errors = 0;

   int m_cred;
   int m_scnt;
   bit m_err;
   bit m_wd;

   function automatic logic [5:0] exp_cause();
      logic [5:0] c;
      bit any;
      c = '0;
      if (bus.inst_v_i !== 1'b1) return c;
      for (int i = 0; i < NS; i++)
         if (bus.src_yumi_req_i[i] && !bus.src_v_i[i]) c[0] = 1'b1;
      for (int i = 0; i < NK; i++)
         if (bus.sink_v_req_i[i] && !bus.sink_ready_and_i[i]) c[1] = 1'b1;
      if (bus.sink_v_req_i[CS] && m_cred == 0) c[2] = 1'b1;
      if (bus.wfq_v_i) begin
         any = 0;
         for (int i = 0; i < NS; i++)
            if (bus.wfq_mask_i[i] && bus.src_v_i[i]) any = 1;
         if (!any) c[3] = 1'b1;
      end
      for (int i = 0; i < NF; i++)
         if (bus.fu_use_i[i] && bus.fu_busy_i[i]) c[4] = 1'b1;
      c[5] = bus.global_busy_i;
      return c;
   endfunction

   task automatic idle();
      bus.inst_v_i         = 0;
      bus.src_yumi_req_i   = '0;
      bus.src_v_i          = '0;
      bus.sink_v_req_i     = '0;
      bus.sink_ready_and_i = '0;
      bus.wfq_v_i          = 0;
      bus.wfq_mask_i       = '0;
      bus.fu_use_i         = '0;
      bus.fu_busy_i        = '0;
      bus.global_busy_i    = 0;
      bus.credit_return_i  = 0;
      bus.watchdog_clr_i   = 0;
   endtask

   task automatic model_reset();
      m_cred = MC;
      m_scnt = 0;
      m_err  = 0;
      m_wd   = 0;
   endtask

   // Advance one clock, updating the model from the inputs before the edge.
   task automatic tick();
      logic [5:0] c;
      bit st, send, ret;
      int nc, ns;
      bit ne, nw;
      c    = exp_cause();
      st   = (c != 0);
      send = bus.inst_v_i && !st && bus.sink_v_req_i[CS];
      ret  = bus.credit_return_i;
      nc = m_cred;
      ne = m_err;
      if (send && !ret) nc = m_cred - 1;
      else if (ret && !send) begin
         if (m_cred == MC) ne = 1;
         else nc = m_cred + 1;
      end
      ns = (bus.inst_v_i && st) ? ((m_scnt < WD) ? m_scnt + 1 : WD) : 0;
      nw = m_wd;
      if (bus.watchdog_clr_i) nw = 0;
      if (bus.inst_v_i && st && m_scnt == WD - 1) nw = 1;
      @(posedge clk);
      #1;
      m_cred = nc;
      m_err  = ne;
      m_scnt = ns;
      m_wd   = nw;
   endtask

   task automatic do_reset();
      rst = 1;
      #3;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      idle();
      do_reset();
      #1;
      checks++;
      if (bus.credit_count_o !== 4'(MC) || bus.credits_empty_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_credit got %0d/%b exp %0d/0",
                  bus.credit_count_o, bus.credits_empty_o, MC);
      end
      checks++;
      if (bus.stall_cycles_o !== '0 || bus.watchdog_o !== 1'b0 ||
          bus.credit_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got scnt=%0d wd=%b err=%b exp 0/0/0",
                  bus.stall_cycles_o, bus.watchdog_o, bus.credit_err_o);
      end
      checks++;
      if (bus.stall_o !== 1'b0 || bus.stall_cause_o !== 6'b0) begin
         errors++;
         $display("FAIL reset_stall got %b/%b exp 0/000000",
                  bus.stall_o, bus.stall_cause_o);
      end
   endtask

   task automatic test_src();
      idle();
      bus.inst_v_i       = 1;
      bus.src_yumi_req_i = 4'b0010;
      bus.src_v_i        = 4'b1101;
      #1;
      checks++;
      if (bus.stall_o !== 1'b1 || bus.stall_cause_o !== 6'b000001 ||
          bus.src_yumi_o !== 4'b0000) begin
         errors++;
         $display("FAIL src_empty got st=%b cause=%b yumi=%b exp 1/000001/0000",
                  bus.stall_o, bus.stall_cause_o, bus.src_yumi_o);
      end
      tick();
      bus.src_v_i = 4'b1111;
      #1;
      checks++;
      if (bus.stall_o !== 1'b0 || bus.stall_cause_o !== 6'b0 ||
          bus.src_yumi_o !== 4'b0010) begin
         errors++;
         $display("FAIL src_ready got st=%b cause=%b yumi=%b exp 0/000000/0010",
                  bus.stall_o, bus.stall_cause_o, bus.src_yumi_o);
      end
      tick();
   endtask

   task automatic test_credit();
      idle();
      do_reset();
      bus.inst_v_i         = 1;
      bus.sink_v_req_i     = 2'b10;
      bus.sink_ready_and_i = 2'b11;
      for (int i = 0; i < MC; i++) begin
         #1;
         checks++;
         if (bus.stall_o !== 1'b0 || bus.sink_v_o !== 2'b10) begin
            errors++;
            $display("FAIL credit_send%0d got st=%b sv=%b exp 0/10",
                     i, bus.stall_o, bus.sink_v_o);
         end
         tick();
         checks++;
         if (bus.credit_count_o !== 4'(MC - 1 - i)) begin
            errors++;
            $display("FAIL credit_count%0d got %0d exp %0d",
                     i, bus.credit_count_o, MC - 1 - i);
         end
      end
      checks++;
      if (bus.credits_empty_o !== 1'b1) begin
         errors++;
         $display("FAIL credit_empty got %b exp 1", bus.credits_empty_o);
      end
      #1;
      checks++;
      if (bus.stall_o !== 1'b1 || bus.stall_cause_o !== 6'b000100 ||
          bus.sink_v_o !== 2'b00) begin
         errors++;
         $display("FAIL credit_stall got st=%b cause=%b sv=%b exp 1/000100/00",
                  bus.stall_o, bus.stall_cause_o, bus.sink_v_o);
      end
      bus.credit_return_i = 1;
      #1;
      checks++;
      if (bus.stall_o !== 1'b1 || bus.stall_cause_o !== 6'b000100) begin
         errors++;
         $display("FAIL credit_ret_same got st=%b cause=%b exp 1/000100",
                  bus.stall_o, bus.stall_cause_o);
      end
      tick();
      bus.credit_return_i = 0;
      #1;
      checks++;
      if (bus.credit_count_o !== 4'd1 || bus.stall_o !== 1'b0 ||
          bus.sink_v_o !== 2'b10) begin
         errors++;
         $display("FAIL credit_resume got cnt=%0d st=%b sv=%b exp 1/0/10",
                  bus.credit_count_o, bus.stall_o, bus.sink_v_o);
      end
      tick();
      checks++;
      if (bus.credit_count_o !== 4'd0) begin
         errors++;
         $display("FAIL credit_back0 got %0d exp 0", bus.credit_count_o);
      end
   endtask

   task automatic test_simul_and_overflow();
      idle();
      bus.credit_return_i = 1;
      repeat (3) tick();
      bus.inst_v_i         = 1;
      bus.sink_v_req_i     = 2'b10;
      bus.sink_ready_and_i = 2'b11;
      #1;
      checks++;
      if (bus.credit_count_o !== 4'd3 || bus.sink_v_o !== 2'b10) begin
         errors++;
         $display("FAIL simul_pre got cnt=%0d sv=%b exp 3/10",
                  bus.credit_count_o, bus.sink_v_o);
      end
      tick();
      checks++;
      if (bus.credit_count_o !== 4'd3) begin
         errors++;
         $display("FAIL simul_hold got %0d exp 3", bus.credit_count_o);
      end
      bus.inst_v_i     = 0;
      bus.sink_v_req_i = '0;
      repeat (5) tick();
      checks++;
      if (bus.credit_count_o !== 4'(MC) || bus.credit_err_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full got cnt=%0d err=%b exp %0d/0",
                  bus.credit_count_o, bus.credit_err_o, MC);
      end
      tick();
      bus.credit_return_i = 0;
      repeat (2) tick();
      checks++;
      if (bus.credit_count_o !== 4'(MC) || bus.credit_err_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_err got cnt=%0d err=%b exp %0d/1",
                  bus.credit_count_o, bus.credit_err_o, MC);
      end
   endtask

   task automatic test_watchdog();
      idle();
      do_reset();
      bus.inst_v_i  = 1;
      bus.fu_use_i  = 7'b0000100;
      bus.fu_busy_i = 7'b0000100;
      #1;
      checks++;
      if (bus.stall_cause_o !== 6'b010000) begin
         errors++;
         $display("FAIL wd_cause got %b exp 010000", bus.stall_cause_o);
      end
      for (int k = 1; k <= WD; k++) begin
         tick();
         checks++;
         if (bus.stall_cycles_o !== 5'(k) || bus.watchdog_o !== (k == WD)) begin
            errors++;
            $display("FAIL wd_cycle%0d got scnt=%0d wd=%b exp %0d/%b",
                     k, bus.stall_cycles_o, bus.watchdog_o, k, k == WD);
         end
      end
      bus.fu_busy_i = '0;
      tick();
      checks++;
      if (bus.stall_cycles_o !== '0 || bus.watchdog_o !== 1'b1) begin
         errors++;
         $display("FAIL wd_release got scnt=%0d wd=%b exp 0/1",
                  bus.stall_cycles_o, bus.watchdog_o);
      end
      bus.watchdog_clr_i = 1;
      tick();
      bus.watchdog_clr_i = 0;
      checks++;
      if (bus.watchdog_o !== 1'b0) begin
         errors++;
         $display("FAIL wd_clear got %b exp 0", bus.watchdog_o);
      end
   endtask

   task automatic test_wfq();
      idle();
      bus.inst_v_i   = 1;
      bus.wfq_v_i    = 1;
      bus.wfq_mask_i = 4'b1001;
      bus.src_v_i    = 4'b0110;
      #1;
      checks++;
      if (bus.stall_o !== 1'b1 || bus.stall_cause_o !== 6'b001000) begin
         errors++;
         $display("FAIL wfq_wait got st=%b cause=%b exp 1/001000",
                  bus.stall_o, bus.stall_cause_o);
      end
      tick();
      bus.src_v_i = 4'b0001;
      #1;
      checks++;
      if (bus.stall_o !== 1'b0 || bus.stall_cause_o !== 6'b0) begin
         errors++;
         $display("FAIL wfq_go got st=%b cause=%b exp 0/000000",
                  bus.stall_o, bus.stall_cause_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      do_reset();
      bus.inst_v_i         = 1;
      bus.sink_v_req_i     = 2'b10;
      bus.sink_ready_and_i = 2'b11;
      repeat (MC - 2) tick();
      bus.sink_v_req_i  = '0;
      bus.global_busy_i = 1;
      repeat (5) tick();
      checks++;
      if (bus.credit_count_o !== 4'd2 || bus.stall_cycles_o !== 5'd5) begin
         errors++;
         $display("FAIL mid_pre got cnt=%0d scnt=%0d exp 2/5",
                  bus.credit_count_o, bus.stall_cycles_o);
      end
      #2;
      rst = 1;
      #1;
      checks++;
      if (bus.credit_count_o !== 4'(MC) || bus.stall_cycles_o !== '0 ||
          bus.watchdog_o !== 1'b0 || bus.credit_err_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got cnt=%0d scnt=%0d wd=%b err=%b exp %0d/0/0/0",
                  bus.credit_count_o, bus.stall_cycles_o,
                  bus.watchdog_o, bus.credit_err_o, MC);
      end
      bus.inst_v_i         = 0;
      bus.src_yumi_req_i   = '1;
      bus.sink_v_req_i     = '1;
      bus.sink_ready_and_i = '0;
      bus.wfq_v_i          = 1;
      bus.fu_use_i         = '1;
      bus.fu_busy_i        = '1;
      #1;
      checks++;
      if (bus.stall_o !== 1'b0 || bus.stall_cause_o !== 6'b0 ||
          bus.src_yumi_o !== '0 || bus.sink_v_o !== '0) begin
         errors++;
         $display("FAIL inst_idle got st=%b cause=%b yumi=%b sv=%b exp all 0",
                  bus.stall_o, bus.stall_cause_o, bus.src_yumi_o, bus.sink_v_o);
      end
      rst = 0;
      model_reset();
      idle();
   endtask

   task automatic test_random();
      logic [5:0] c;
      bit st;
      logic [NS-1:0] ey;
      logic [NK-1:0] es;
      idle();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         bus.inst_v_i         = ($urandom_range(0, 9) < 8);
         bus.src_yumi_req_i   = NS'($urandom);
         bus.src_v_i          = NS'($urandom | $urandom);
         bus.sink_v_req_i     = NK'($urandom);
         bus.sink_ready_and_i = NK'($urandom | $urandom | $urandom);
         bus.wfq_v_i          = ($urandom_range(0, 9) == 0);
         bus.wfq_mask_i       = NS'($urandom);
         bus.fu_use_i         = NF'($urandom);
         bus.fu_busy_i        = NF'($urandom & $urandom & $urandom);
         bus.global_busy_i    = ($urandom_range(0, 9) == 0);
         bus.credit_return_i  = ($urandom_range(0, 2) == 0);
         bus.watchdog_clr_i   = ($urandom_range(0, 19) == 0);
         #1;
         c  = exp_cause();
         st = (c != 0);
         ey = (bus.inst_v_i && !st) ? bus.src_yumi_req_i : '0;
         es = (bus.inst_v_i && !st) ? bus.sink_v_req_i : '0;
         checks++;
         if (bus.stall_o !== st || bus.stall_cause_o !== c) begin
            errors++;
            $display("FAIL rnd_stall n=%0d got %b/%b exp %b/%b",
                     n, bus.stall_o, bus.stall_cause_o, st, c);
         end
         checks++;
         if (bus.src_yumi_o !== ey || bus.sink_v_o !== es) begin
            errors++;
            $display("FAIL rnd_fire n=%0d got %b/%b exp %b/%b",
                     n, bus.src_yumi_o, bus.sink_v_o, ey, es);
         end
         checks++;
         if (bus.credit_count_o !== 4'(m_cred) ||
             bus.credits_empty_o !== (m_cred == 0) ||
             bus.credit_err_o !== m_err) begin
            errors++;
            $display("FAIL rnd_credit n=%0d got %0d/%b/%b exp %0d/%b/%b",
                     n, bus.credit_count_o, bus.credits_empty_o,
                     bus.credit_err_o, m_cred, m_cred == 0, m_err);
         end
         checks++;
         if (bus.stall_cycles_o !== 5'(m_scnt) || bus.watchdog_o !== m_wd) begin
            errors++;
            $display("FAIL rnd_wd n=%0d got %0d/%b exp %0d/%b",
                     n, bus.stall_cycles_o, bus.watchdog_o, m_scnt, m_wd);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1;
      idle();
      model_reset();
      #12;
      rst = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_src();
      test_credit();
      test_simul_and_overflow();
      test_watchdog();
      test_wfq();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
